chan_err_inj: RTL and testbench
===============================

CHAN_ERR_INJ -- requirements
Module: chan_err_inj

Interface
REQ-001 Parameters (name, default, meaning):
- SYM_W, 2, symbol width (encoder output bits per symbol).
- PER_W, 8, width of the period and burst-length configuration fields.
- CNT_W, 16, width of the symbol and error counters.
- SEED, 16'hACE1, LFSR reload value; a SEED of 0 SHALL be replaced by 16'h0001.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- clear_i, in, 1, synchronous clear of counters, window and LFSR.
- mode_i, in, 2, injection mode: 0 OFF, 1 PERIODIC, 2 BURST, 3 RANDOM.
- period_i, in, PER_W, trigger period in valid symbols; 0 means never trigger.
- burst_len_i, in, PER_W, consecutive corrupted symbols per BURST trigger.
- thresh_i, in, 8, RANDOM mode: inject when lfsr[7:0] < thresh_i.
- mask_i, in, SYM_W, bits XORed into a corrupted symbol.
- window_i, in, CNT_W, number of symbols eligible for injection.
- valid_i, in, 1, input symbol strobe.
- sym_i, in, SYM_W, encoder symbol.
- valid_o, out, 1, registered copy of valid_i.
- sym_o, out, SYM_W, possibly corrupted symbol to the decoder.
- err_o, out, 1, high with valid_o when sym_o was corrupted.
- sym_ct_o, out, CNT_W, valid symbols seen since reset or clear.
- err_sym_ct_o, out, CNT_W, corrupted-symbol count.
- err_bit_ct_o, out, CNT_W, flipped-bit count.

Function
REQ-003 Latency SHALL be exactly 1 cycle, valid_i/sym_i to valid_o/sym_o/err_o, with no back-pressure.
REQ-004 On an uncorrupted valid symbol, sym_o SHALL equal sym_i; on a corrupted one, sym_o SHALL equal sym_i ^ mask_i.
REQ-005 When valid_i=0: valid_o=0, err_o=0, sym_o holds its previous value, and no counter, phase or LFSR advances.
REQ-006 The symbol index k SHALL equal sym_ct_o before increment; injection is permitted only while k < window_i.
REQ-007 The FSM SHALL have states RUN, BURST and DONE; it enters DONE when k reaches window_i and stays there, passing data clean, until rst or clear_i.
REQ-008 The phase counter SHALL count valid symbols 0..period_i-1 and wrap; a trigger occurs when phase = period_i-1; period_i=0 SHALL give no triggers.
REQ-009 PERIODIC mode SHALL corrupt exactly the trigger symbol.
REQ-010 BURST mode: on a trigger, RUN->BURST with remaining count = burst_len_i.
- The trigger symbol and each following valid symbol are corrupted until the count is exhausted; then BURST->RUN.
- Triggers arriving during BURST are ignored.
- burst_len_i=0 corrupts nothing.
REQ-011 RANDOM mode SHALL use a 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced once per valid symbol; a symbol is corrupted when lfsr[7:0] < thresh_i, sampled before the advance.
REQ-012 OFF mode SHALL corrupt nothing, while counters, phase and LFSR continue to advance.
REQ-013 A change of mode_i while in BURST SHALL abort the burst (BURST->RUN) on that cycle.
REQ-014 Counter updates:
- sym_ct_o +1 per valid symbol.
- err_sym_ct_o +1 per corrupted symbol.
- err_bit_ct_o + popcount(mask_i) per corrupted symbol.
- All counters saturate at all-ones and never wrap.
REQ-015 mask_i=0 SHALL still count a corrupted symbol in err_sym_ct_o but add 0 to err_bit_ct_o; err_o SHALL still assert.
REQ-016 clear_i SHALL take effect on the next edge:
- Zero all counters and the phase counter.
- Reload the LFSR with SEED and force the FSM to RUN.
- The symbol presented in the same cycle is passed clean and not counted.
REQ-017 If rst and clear_i are both asserted, rst SHALL take precedence.

Reset
REQ-018 On rst the block SHALL set:
- valid_o=0, err_o=0, sym_o=0.
- All counters and the phase counter = 0.
- LFSR = SEED; FSM = RUN.
REQ-019 Reset asserted mid-burst or mid-window SHALL abandon the operation with no residual corruption on the first post-reset symbol.

Structure
REQ-020 Package chan_err_pkg SHALL hold the mode enum, the FSM state enum and the LFSR tap constant.
REQ-021 The LFSR SHALL be a sub-module lfsr16 (ports clk, rst, load_i, seed_i, adv_i, q_o); all other logic is flat.

Verification
REQ-022 PERIODIC, period_i=16, mask_i=2'b01, window_i=256, 300 consecutive valid symbols -> err_o on k=15,31,...,255 only; err_sym_ct_o=16; err_bit_ct_o=16; sym_ct_o=300.
REQ-023 BURST, period_i=32, burst_len_i=4, mask_i=2'b11, window_i=64 -> corrupted k=31..34; the burst starting at k=63 is cut at the window so only k=63 is corrupted; err_bit_ct_o=10.
REQ-024 RANDOM, thresh_i=0 -> no errors; thresh_i=255 -> error rate within 1 per 256; repeating after clear_i reproduces an identical err_o sequence.
REQ-025 BURST, burst_len_i=8: switch mode_i to OFF after the 3rd corrupted symbol -> exactly 3 corrupted, FSM back in RUN.
REQ-026 CNT_W=4, PERIODIC, period_i=1, 20 valid symbols with window_i=15 and then window_i=0xF -> sym_ct_o saturates at 15; err_sym_ct_o=15; no wrap.
REQ-027 Assert rst during a burst and clear_i together with valid_i -> all outputs and counters match REQ-018 and REQ-016; the next symbol is passed clean.

Source files
------------

// File: rtl/chan_err_pkg.sv
// Shared types and constants for the channel error injector.
package chan_err_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_BURST    = 2'd2,
    MODE_RANDOM   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload and per-symbol advance.
module lfsr16
  import chan_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        adv_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (adv_i) q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst || load_i) q_q <= seed_i;
    else               q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/chan_err_inj.sv
// Channel error injector: passes encoder symbols through with one cycle of
// latency, XOR-corrupting selected symbols in periodic, burst or random modes.
module chan_err_inj
  import chan_err_pkg::*;
#(
  parameter int          SYM_W = 2,
  parameter int          PER_W = 8,
  parameter int          CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [1:0]       mode_i,
  input  logic [PER_W-1:0] period_i,
  input  logic [PER_W-1:0] burst_len_i,
  input  logic [7:0]       thresh_i,
  input  logic [SYM_W-1:0] mask_i,
  input  logic [CNT_W-1:0] window_i,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic             err_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] err_sym_ct_o,
  output logic [CNT_W-1:0] err_bit_ct_o
);

  // An all-zero seed would lock the LFSR, so substitute a legal one.
  localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [PER_W-1:0] PER_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  function automatic logic [CNT_W:0] popcnt(input logic [SYM_W-1:0] v);
    popcnt = '0;
    for (int i = 0; i < SYM_W; i++) popcnt = popcnt + {{CNT_W{1'b0}}, v[i]};
  endfunction

  mode_e            mode;
  state_e           state_q, state_d;
  logic [PER_W-1:0] phase_q, phase_d, rem_q, rem_d;
  logic [CNT_W-1:0] sym_ct_q, sym_ct_d, err_sym_ct_q, err_sym_ct_d;
  logic [CNT_W-1:0] err_bit_ct_q, err_bit_ct_d;
  logic [CNT_W:0]   bit_sum;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             valid_q, err_q, corrupt, in_win, trigger, abort;
  logic [15:0]      lfsr_q;
  logic             unused_lfsr_hi;

  assign mode           = mode_e'(mode_i);
  assign unused_lfsr_hi = ^lfsr_q[15:8];

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (clear_i),
    .seed_i (SEED_EFF),
    .adv_i  (valid_i),
    .q_o    (lfsr_q)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rem_d        = rem_q;
    sym_ct_d     = sym_ct_q;
    err_sym_ct_d = err_sym_ct_q;
    err_bit_ct_d = err_bit_ct_q;
    sym_d        = sym_q;
    corrupt      = 1'b0;
    bit_sum      = {1'b0, err_bit_ct_q} + popcnt(mask_i);
    in_win       = sym_ct_q < window_i;
    trigger      = (period_i != '0) && (phase_q == period_i - PER_ONE);
    abort        = (state_q == ST_BURST) && (mode != MODE_BURST);

    if (abort) begin
      state_d = ST_RUN;
    end else if (valid_i) begin
      if (!in_win) begin
        state_d = ST_DONE;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            unique case (mode)
              MODE_PERIODIC: corrupt = trigger;
              MODE_BURST: begin
                if (trigger && burst_len_i != '0) begin
                  corrupt = 1'b1;
                  // rem counts the symbols still owed after this trigger.
                  if (burst_len_i != PER_ONE) begin
                    state_d = ST_BURST;
                    rem_d   = burst_len_i - PER_ONE;
                  end
                end
              end
              MODE_RANDOM:   corrupt = lfsr_q[7:0] < thresh_i;
              default:       corrupt = 1'b0;
            endcase
          end
          ST_BURST: begin
            corrupt = 1'b1;
            rem_d   = rem_q - PER_ONE;
            if (rem_q == PER_ONE) state_d = ST_RUN;
          end
          default: state_d = ST_DONE;
        endcase
      end
    end

    if (valid_i) begin
      sym_d    = sym_i ^ (corrupt ? mask_i : '0);
      phase_d  = (period_i == '0 || phase_q >= period_i - PER_ONE) ? '0 : phase_q + PER_ONE;
      sym_ct_d = (sym_ct_q == '1) ? sym_ct_q : sym_ct_q + CNT_ONE;
      if (corrupt) begin
        err_sym_ct_d = (err_sym_ct_q == '1) ? err_sym_ct_q : err_sym_ct_q + CNT_ONE;
        err_bit_ct_d = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      phase_q      <= '0;
      rem_q        <= '0;
      sym_ct_q     <= '0;
      err_sym_ct_q <= '0;
      err_bit_ct_q <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      sym_q        <= '0;
    end else if (clear_i) begin
      // The symbol accompanying a clear is forwarded clean and uncounted.
      state_q      <= ST_RUN;
      phase_q      <= '0;
      rem_q        <= '0;
      sym_ct_q     <= '0;
      err_sym_ct_q <= '0;
      err_bit_ct_q <= '0;
      valid_q      <= valid_i;
      err_q        <= 1'b0;
      if (valid_i) sym_q <= sym_i;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rem_q        <= rem_d;
      sym_ct_q     <= sym_ct_d;
      err_sym_ct_q <= err_sym_ct_d;
      err_bit_ct_q <= err_bit_ct_d;
      valid_q      <= valid_i;
      err_q        <= corrupt;
      sym_q        <= sym_d;
    end
  end

  assign valid_o      = valid_q;
  assign sym_o        = sym_q;
  assign err_o        = err_q;
  assign sym_ct_o     = sym_ct_q;
  assign err_sym_ct_o = err_sym_ct_q;
  assign err_bit_ct_o = err_bit_ct_q;

endmodule

// File: tb/tb_chan_err_inj.sv
// Directed self-checking bench for chan_err_inj, with a narrow-counter
// instance alongside for saturation behaviour.
module tb_chan_err_inj;
  import chan_err_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clear_i, valid_i;
  logic [1:0]  mode_i, mask_i, sym_i;
  logic [7:0]  period_i, burst_len_i, thresh_i;
  logic [15:0] window_i;
  logic [3:0]  window4_i;

  logic        valid_o, err_o;
  logic [1:0]  sym_o;
  logic [15:0] sym_ct_o, err_sym_ct_o, err_bit_ct_o;
  logic        valid4_o, err4_o;
  logic [1:0]  sym4_o;
  logic [3:0]  sym_ct4_o, err_sym_ct4_o, err_bit_ct4_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chan_err_inj dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .mode_i(mode_i),
    .period_i(period_i), .burst_len_i(burst_len_i), .thresh_i(thresh_i),
    .mask_i(mask_i), .window_i(window_i), .valid_i(valid_i), .sym_i(sym_i),
    .valid_o(valid_o), .sym_o(sym_o), .err_o(err_o), .sym_ct_o(sym_ct_o),
    .err_sym_ct_o(err_sym_ct_o), .err_bit_ct_o(err_bit_ct_o)
  );

  chan_err_inj #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear_i(clear_i), .mode_i(mode_i),
    .period_i(period_i), .burst_len_i(burst_len_i), .thresh_i(thresh_i),
    .mask_i(mask_i), .window_i(window4_i), .valid_i(valid_i), .sym_i(sym_i),
    .valid_o(valid4_o), .sym_o(sym4_o), .err_o(err4_o), .sym_ct_o(sym_ct4_o),
    .err_sym_ct_o(err_sym_ct4_o), .err_bit_ct_o(err_bit_ct4_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] s);
    valid_i = 1'b1;
    sym_i   = s;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic do_clear(input logic vld, input logic [1:0] s);
    clear_i = 1'b1;
    valid_i = vld;
    sym_i   = s;
    @(posedge clk); #1;
    clear_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic lfsr_step(inout logic [15:0] l);
    l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endtask

  initial begin
    int           bad, exp_ct;
    logic         e;
    logic [15:0]  l;
    logic [199:0] seq1, seq2;

    rst = 1'b1; clear_i = 1'b0; valid_i = 1'b1; sym_i = 2'b11;
    mode_i = MODE_OFF; period_i = '0; burst_len_i = '0; thresh_i = '0;
    mask_i = '0; window_i = '0; window4_i = 4'hF;

    // Reset state, with a symbol presented during reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_o", valid_o, 0);
    check("rst_err_o", err_o, 0);
    check("rst_sym_o", sym_o, 0);
    check("rst_sym_ct", sym_ct_o, 0);
    check("rst_err_sym_ct", err_sym_ct_o, 0);
    check("rst_err_bit_ct", err_bit_ct_o, 0);
    rst = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;

    // Periodic: errors on k=15,31,...,255 only.
    mode_i = MODE_PERIODIC; period_i = 8'd16; mask_i = 2'b01; window_i = 16'd256;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      send(2'(k));
      e = (k % 16 == 15) && (k < 256);
      if (valid_o !== 1'b1 || err_o !== e || sym_o !== (2'(k) ^ (e ? 2'b01 : 2'b00))) bad++;
    end
    check("periodic_pattern", bad, 0);
    check("periodic_err_sym_ct", err_sym_ct_o, 16);
    check("periodic_err_bit_ct", err_bit_ct_o, 16);
    check("periodic_sym_ct", sym_ct_o, 300);
    @(posedge clk); #1;
    check("idle_valid_o", valid_o, 0);
    check("idle_err_o", err_o, 0);
    check("idle_sym_hold", sym_o, 2'b11);
    check("idle_sym_ct", sym_ct_o, 300);

    // Burst: k=31..34 and k=63 (cut by the window).
    mode_i = MODE_BURST; period_i = 8'd32; burst_len_i = 8'd4; mask_i = 2'b11; window_i = 16'd64;
    do_clear(1'b1, 2'b10);
    check("clear_valid_o", valid_o, 1);
    check("clear_sym_o", sym_o, 2'b10);
    check("clear_err_o", err_o, 0);
    check("clear_sym_ct", sym_ct_o, 0);
    check("clear_err_bit_ct", err_bit_ct_o, 0);
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      send(2'(k));
      e = (k >= 31 && k <= 34) || k == 63;
      if (err_o !== e || sym_o !== (2'(k) ^ (e ? 2'b11 : 2'b00))) bad++;
    end
    check("burst_pattern", bad, 0);
    check("burst_err_sym_ct", err_sym_ct_o, 5);
    check("burst_err_bit_ct", err_bit_ct_o, 10);
    check("burst_sym_ct", sym_ct_o, 80);

    // burst_len 0 corrupts nothing.
    period_i = 8'd4; burst_len_i = 8'd0; window_i = 16'hFFFF;
    do_clear(1'b0, 2'b00);
    for (int k = 0; k < 12; k++) send(2'(k));
    check("burst0_err_sym_ct", err_sym_ct_o, 0);

    // Random with thresh 0: no errors.
    mode_i = MODE_RANDOM; thresh_i = 8'd0; mask_i = 2'b01;
    do_clear(1'b0, 2'b00);
    for (int k = 0; k < 50; k++) send(2'(k));
    check("rand0_err_sym_ct", err_sym_ct_o, 0);

    // Random with thresh 128, against an LFSR model, then repeated after clear.
    thresh_i = 8'd128;
    do_clear(1'b0, 2'b00);
    l = 16'hACE1; bad = 0; exp_ct = 0;
    for (int k = 0; k < 200; k++) begin
      e = l[7:0] < thresh_i;
      send(2'(k));
      if (err_o !== e) bad++;
      seq1[k] = err_o;
      exp_ct += int'(e);
      lfsr_step(l);
    end
    check("rand128_pattern", bad, 0);
    check("rand128_err_sym_ct", err_sym_ct_o, exp_ct);
    do_clear(1'b0, 2'b00);
    for (int k = 0; k < 200; k++) begin
      send(2'(k));
      seq2[k] = err_o;
    end
    check("rand_repeat_diff_bits", $countones(seq1 ^ seq2), 0);

    // Random with thresh 255: all but lfsr[7:0]==255 corrupted.
    thresh_i = 8'd255;
    do_clear(1'b0, 2'b00);
    l = 16'hACE1; exp_ct = 0;
    for (int k = 0; k < 256; k++) begin
      exp_ct += int'(l[7:0] < 8'd255);
      send(2'(k));
      lfsr_step(l);
    end
    check("rand255_err_sym_ct", err_sym_ct_o, exp_ct);

    // Mask of zero: error still flagged and counted, no bits counted.
    mode_i = MODE_PERIODIC; period_i = 8'd2; mask_i = 2'b00;
    do_clear(1'b0, 2'b00);
    send(2'b01);
    check("mask0_k0_err", err_o, 0);
    send(2'b10);
    check("mask0_k1_err", err_o, 1);
    check("mask0_k1_sym", sym_o, 2'b10);
    send(2'b11); send(2'b00);
    check("mask0_err_sym_ct", err_sym_ct_o, 2);
    check("mask0_err_bit_ct", err_bit_ct_o, 0);

    // Burst of 8 aborted by a mode change after the third corrupted symbol.
    mode_i = MODE_BURST; period_i = 8'd8; burst_len_i = 8'd8; mask_i = 2'b01;
    do_clear(1'b0, 2'b00);
    for (int k = 0; k < 10; k++) send(2'(k));
    check("abort_pre_err_sym_ct", err_sym_ct_o, 3);
    mode_i = MODE_OFF;
    send(2'b10);
    check("abort_cycle_err", err_o, 0);
    check("abort_state", dut.state_q, ST_RUN);
    for (int k = 0; k < 5; k++) send(2'(k));
    check("abort_err_sym_ct", err_sym_ct_o, 3);

    // Narrow counters: saturate at 15 with no wrap.
    mode_i = MODE_PERIODIC; period_i = 8'd1; mask_i = 2'b01; window4_i = 4'hF;
    do_clear(1'b0, 2'b00);
    for (int k = 0; k < 20; k++) send(2'(k));
    check("sat_sym_ct", sym_ct4_o, 15);
    check("sat_err_sym_ct", err_sym_ct4_o, 15);
    check("sat_err_bit_ct", err_bit_ct4_o, 15);
    check("sat_last_err", err4_o, 0);

    // Reset mid-burst, then the next symbol is clean.
    mode_i = MODE_BURST; period_i = 8'd4; burst_len_i = 8'd8; mask_i = 2'b11; window_i = 16'hFFFF;
    do_clear(1'b0, 2'b00);
    for (int k = 0; k < 5; k++) send(2'(k));
    check("midburst_err", err_o, 1);
    rst = 1'b1; valid_i = 1'b1; sym_i = 2'b10;
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    check("midrst_valid_o", valid_o, 0);
    check("midrst_sym_o", sym_o, 0);
    check("midrst_err_sym_ct", err_sym_ct_o, 0);
    send(2'b01);
    check("postrst_err", err_o, 0);
    check("postrst_sym", sym_o, 2'b01);
    check("postrst_sym_ct", sym_ct_o, 1);

    // rst wins over clear_i.
    rst = 1'b1; clear_i = 1'b1; valid_i = 1'b1; sym_i = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; clear_i = 1'b0; valid_i = 1'b0;
    check("rst_clear_valid_o", valid_o, 0);
    check("rst_clear_sym_o", sym_o, 0);
    send(2'b11);
    check("rst_clear_next_sym", sym_o, 2'b11);
    check("rst_clear_next_err", err_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
